rej_eta_sampler: RTL and testbench



---
 rtl/mldsa_pkg.sv | 18 +
 rtl/rej_eta_map.sv | 49 ++++
 rtl/rej_eta_sampler.sv | 108 ++++++++++
 tb/tb_rej_eta_sampler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mldsa_pkg.sv
// Shared ML-DSA constants and the ExpandS sampler state encoding.
package mldsa_pkg;

    localparam int          N    = 256;          // coefficients per polynomial
    localparam logic [22:0] Q    = 23'd8380417;  // ML-DSA modulus

    // Encodings of the sampler's eta_sel input.
    localparam logic ETA2 = 1'b0;
    localparam logic ETA4 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } sampler_state_e;

endpackage

// File: rtl/rej_eta_map.sv
// Combinational nibble-to-coefficient map for the eta rejection sampler.
// Produces the accept flag and the coefficient already reduced mod Q.
module rej_eta_map
    import mldsa_pkg::*;
(
    input  logic [3:0]  nibble,
    input  logic        eta_sel,
    output logic        accept,
    output logic [22:0] coeff
);

    logic [2:0] mag;
    logic       neg;

    // Decode the nibble into sign/magnitude, then fold negatives into Q + value.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        accept = 1'b0;
        mag    = 3'd0;
        neg    = 1'b0;
        case (eta_sel)
            ETA2: begin
                accept = (nibble < 4'd15);
                // value = 2 - (b mod 5)
                case (nibble)
                    4'd0, 4'd5, 4'd10: mag = 3'd2;
                    4'd1, 4'd6, 4'd11: mag = 3'd1;
                    4'd2, 4'd7, 4'd12: mag = 3'd0;
                    4'd3, 4'd8, 4'd13: begin mag = 3'd1; neg = 1'b1; end
                    4'd4, 4'd9, 4'd14: begin mag = 3'd2; neg = 1'b1; end
                    default:           mag = 3'd0;
                endcase
            end
            ETA4: begin
                accept = (nibble < 4'd9);
                // value = 4 - b; rejected nibbles produce don't-care magnitudes
                if (nibble <= 4'd4) begin
                    mag = 3'(4'd4 - nibble);
                end else begin
                    mag = 3'(nibble - 4'd4);
                    neg = 1'b1;
                end
            end
            default: ;
        endcase
        coeff = neg ? (Q - {20'd0, mag}) : {20'd0, mag};
    end

endmodule

// File: rtl/rej_eta_sampler.sv
// ML-DSA ExpandS rejection sampler: scans 64-bit squeeze words one nibble
// per cycle and emits the 256 coefficients of one polynomial in [-eta, eta].
module rej_eta_sampler
    import mldsa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        eta_sel,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [22:0] coeff,
    output logic        coeff_valid,
    output logic [7:0]  coeff_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0] COUNT_FULL = 9'(N);

    sampler_state_e state_q, state_d;
    logic           eta_q;
    logic [63:0]    word_q;
    logic [3:0]     ptr_q;
    logic [8:0]     count_q, count_d;
    logic [3:0]     nibble;
    logic           map_accept;
    logic [22:0]    map_coeff;
    logic           scan_emit;

    assign nibble = word_q[{ptr_q, 2'b00} +: 4];

    rej_eta_map u_map (
        .nibble  (nibble),
        .eta_sel (eta_q),
        .accept  (map_accept),
        .coeff   (map_coeff)
    );

    // Once the count hits N the remaining nibbles of the word are ignored.
    assign scan_emit = (state_q == SCAN) && (count_q != COUNT_FULL) && map_accept;
    assign count_d   = count_q + {8'd0, scan_emit};

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic plus the state-decoded handshake and status outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        busy     = (state_q != IDLE);
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SCAN;
            end
            SCAN: begin
                // Completion is taken the cycle after the last accept so done
                // lands one cycle after the final coeff_valid.
                if (count_q == COUNT_FULL)                     state_d = DONE;
                else if (ptr_q == 4'd15 && count_d != COUNT_FULL) state_d = LOAD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latched eta, word register, nibble pointer, count and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the word register is cleared on reset so a half-scanned word never leaks into the next run.
            eta_q       <= ETA2;
            word_q      <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
            coeff       <= '0;
            coeff_idx   <= '0;
            coeff_valid <= 1'b0;
        end else begin
            coeff_valid <= scan_emit;
            if (state_q == IDLE && start) begin
                eta_q   <= eta_sel;
                count_q <= '0;
            end
            if (state_q == LOAD && in_valid) begin
                word_q <= in_data;
                ptr_q  <= '0;
            end
            if (state_q == SCAN) ptr_q <= ptr_q + 4'd1;
            if (scan_emit) begin
                coeff     <= map_coeff;
                coeff_idx <= count_q[7:0];
                count_q   <= count_d;
            end
        end
    end

endmodule

// File: tb/tb_rej_eta_sampler.sv
// Directed self-checking bench for rej_eta_sampler.
module tb_rej_eta_sampler;

    localparam int Q = 8380417;

    logic        clk = 1'b0;
    logic        reset, start, eta_sel, in_valid;
    logic [63:0] in_data;
    logic        in_ready, coeff_valid, busy, done;
    logic [22:0] coeff;
    logic [7:0]  coeff_idx;

    rej_eta_sampler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .eta_sel     (eta_sel),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .coeff       (coeff),
        .coeff_valid (coeff_valid),
        .coeff_idx   (coeff_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int idx;
        int val;
    } ev_t;

    ev_t         evs[$];
    int          done_cyc[$];
    int          hs_cyc[$];
    int          exp_q[$];
    int          exp_words;
    logic [63:0] src_q[$];
    logic [63:0] words_q[$];
    int          cyc       = 0;
    int          stall_cnt = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          t0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference coefficient for one nibble.
    function automatic int model(input bit eta4, input int b, output bit acc);
        int v;
        if (eta4) begin
            acc = (b < 9);
            v   = 4 - b;
        end else begin
            acc = (b < 15);
            v   = 2 - (b % 5);
        end
        return (v < 0) ? Q + v : v;
    endfunction

    // Expected coefficient stream and word count for the words queued in words_q.
    task automatic build_exp(input bit eta4);
        logic [63:0] w;
        bit          acc;
        int          v;
        exp_q.delete();
        exp_words = 0;
        for (int i = 0; i < words_q.size() && exp_q.size() < 256; i++) begin
            w = words_q[i];
            exp_words++;
            for (int k = 0; k < 16; k++) begin
                if (exp_q.size() < 256) begin
                    v = model(eta4, int'(w[4*k +: 4]), acc);
                    if (acc) exp_q.push_back(v);
                end
            end
        end
    endtask

    // One clock: log the handshake of the ending cycle, then drive and sample the new one.
    task automatic tick();
        bit  hs;
        ev_t e;
        hs = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (hs) hs_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        if (hs) void'(src_q.pop_front());
        in_valid = (src_q.size() > 0) && (stall_cnt == 0);
        in_data  = (src_q.size() > 0) ? src_q[0] : 64'd0;
        if (stall_cnt > 0) stall_cnt--;
        if (coeff_valid === 1'b1) begin
            e.cyc = cyc;
            e.idx = int'(coeff_idx);
            e.val = int'(coeff);
            evs.push_back(e);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
    endtask

    // Start a polynomial with the words already in src_q.
    task automatic new_poly(input string tag, input bit eta4, input int stall);
        evs.delete();
        done_cyc.delete();
        hs_cyc.delete();
        words_q = src_q;
        build_exp(eta4);
        stall_cnt = stall;
        in_valid  = (src_q.size() > 0) && (stall == 0);
        in_data   = (src_q.size() > 0) ? src_q[0] : 64'd0;
        start     = 1'b1;
        eta_sel   = eta4;
        t0        = cyc;
        tick();
        eta_sel = ~eta4;  // must be ignored after latching
        check({tag, "_busy_t1"}, busy, 1);
        check({tag, "_ready_t1"}, in_ready, 1);
    endtask

    // Run until done, then confirm the block is back in IDLE one cycle later.
    task automatic run_done(input string tag);
        int budget = 0;
        while (done_cyc.size() == 0 && budget < 1500) begin
            tick();
            budget++;
        end
        check({tag, "_done_seen"}, (budget < 1500), 1);
        check({tag, "_busy_at_done"}, busy, 1);
        tick();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, 0);
        check({tag, "_idle_ready"}, in_ready, 0);
    endtask

    // Compare the captured stream against the model.
    task automatic check_stream(input string tag);
        int bad = 0;
        int n   = (evs.size() < exp_q.size()) ? evs.size() : exp_q.size();
        check({tag, "_count"}, evs.size(), exp_q.size());
        for (int i = 0; i < n; i++)
            if (evs[i].idx != i || evs[i].val != exp_q[i]) bad++;
        check({tag, "_stream_bad"}, bad, 0);
        check({tag, "_words"}, hs_cyc.size(), exp_words);
        check({tag, "_done_pulses"}, done_cyc.size(), 1);
        if (evs.size() > 0 && done_cyc.size() > 0)
            check({tag, "_done_after_last"}, done_cyc[0], evs[evs.size()-1].cyc + 1);
        else
            check({tag, "_done_after_last"}, 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        reset    = 1'b0;
        start    = 1'b0;
        eta_sel  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_coeff_valid", coeff_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coeff", coeff, 0);
        check("rst_coeff_idx", coeff_idx, 0);
        reset = 1'b1;
        tick();

        // eta=2, all-zero words; a stray start mid-run must be ignored.
        src_q.delete();
        repeat (20) src_q.push_back(64'd0);
        new_poly("zero2", 1'b0, 0);
        repeat (30) tick();
        start = 1'b1;
        run_done("zero2");
        check_stream("zero2");
        check("zero2_first_hs", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, t0 + 1);
        check("zero2_first_coeff_cyc", (evs.size() > 0) ? evs[0].cyc : -1, t0 + 3);
        check("zero2_second_hs", (hs_cyc.size() > 1) ? hs_cyc[1] : -1, t0 + 18);
        check("zero2_val_255", (evs.size() == 256) ? evs[255].val : -1, 2);

        // eta=2, all-ones word rejected entirely, then zeros.
        src_q.delete();
        src_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        repeat (17) src_q.push_back(64'd0);
        new_poly("ones2", 1'b0, 0);
        run_done("ones2");
        check_stream("ones2");
        check("ones2_ready_gap", (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1, 17);
        check("ones2_first_coeff_cyc", (evs.size() > 0 && hs_cyc.size() > 1) ? evs[0].cyc - hs_cyc[1] : -1, 2);

        // eta=4, mixed first word, completion mid-word at nibble 6 of word 17.
        src_q.delete();
        src_q.push_back(64'h0000_0000_FEDC_BA98);
        repeat (18) src_q.push_back(64'd0);
        new_poly("mix4", 1'b1, 0);
        run_done("mix4");
        check_stream("mix4");
        if (evs.size() >= 9 && hs_cyc.size() >= 17) begin
            check("mix4_c0_val", evs[0].val, 8380413);
            check("mix4_c0_idx", evs[0].idx, 0);
            check("mix4_c0_cyc", evs[0].cyc - hs_cyc[0], 2);
            check("mix4_c1_val", evs[1].val, 4);
            check("mix4_c1_cyc", evs[1].cyc - hs_cyc[0], 10);
            check("mix4_c8_idx", evs[8].idx, 8);
            check("mix4_c8_cyc", evs[8].cyc - hs_cyc[0], 17);
        end else begin
            check("mix4_short_capture", 0, 1);
        end
        if (evs.size() == 256 && hs_cyc.size() == 17)
            check("mix4_last_cyc", evs[255].cyc - hs_cyc[16], 8);
        else
            check("mix4_last_cyc", 0, 1);

        // eta=2 mod-5 table with a 5-cycle LOAD stall; start taken right after the previous run.
        src_q.delete();
        src_q.push_back(64'hFEDC_BA98_7654_3210);
        repeat (17) src_q.push_back(64'd0);
        new_poly("tab2", 1'b0, 5);
        run_done("tab2");
        check_stream("tab2");
        check("tab2_stall_hs", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, t0 + 6);
        if (evs.size() >= 15) begin
            check("tab2_first_coeff_cyc", evs[0].cyc - hs_cyc[0], 2);
            check("tab2_n0", evs[0].val, 2);
            check("tab2_n1", evs[1].val, 1);
            check("tab2_n2", evs[2].val, 0);
            check("tab2_n3", evs[3].val, 8380416);
            check("tab2_n4", evs[4].val, 8380415);
            check("tab2_n14", evs[14].val, 8380415);
        end else begin
            check("tab2_short_capture", 0, 1);
        end

        // Reset mid-SCAN right when idx 100 is on the output.
        src_q.delete();
        repeat (20) src_q.push_back(64'd0);
        new_poly("rst2", 1'b0, 0);
        budget = 0;
        while (!(evs.size() > 0 && evs[evs.size()-1].idx == 100) && budget < 1500) begin
            tick();
            budget++;
        end
        check("rst_mid_reached_100", (budget < 1500), 1);
        check("rst_mid_valid_100", coeff_valid, 1);
        reset = 1'b0;
        tick();
        check("rst_mid_in_ready", in_ready, 0);
        check("rst_mid_coeff_valid", coeff_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_coeff", coeff, 0);
        check("rst_mid_coeff_idx", coeff_idx, 0);
        reset = 1'b1;
        tick();

        // Fresh run after reset with eta=4 newly latched.
        src_q.delete();
        repeat (20) src_q.push_back(64'd0);
        new_poly("post4", 1'b1, 0);
        run_done("post4");
        check_stream("post4");
        check("post4_c0_val", (evs.size() > 0) ? evs[0].val : -1, 4);
        check("post4_c0_idx", (evs.size() > 0) ? evs[0].idx : -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
